// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 always win simultaneous requests.
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CMP_W   = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                oor;

  assign oor = ({1'b0, addr_q} >= DEPTH_C);

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt_d = !req0;
`else
  logic last_q;
  // last_q resets to 1 so that port 0 wins the first contended grant.
  assign gnt_d = (req0 && req1) ? !last_q : req1;

  always_ff @(posedge clock) begin
    if (!rst_n)                          last_q <= 1'b1;
    else if (state_q == IDLE && (req0 || req1)) last_q <= gnt_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes only in ISSUE, and never for an out-of-range address.
  always_comb begin
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    if (state_q == ISSUE && !oor) begin
      mem_wr = we_q;
      mem_rd = !we_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      if (state_q == IDLE && (req0 || req1)) begin
        gnt_q   <= gnt_d;
        we_q    <= gnt_d ? we1    : we0;
        addr_q  <= gnt_d ? addr1  : addr0;
        wdata_q <= gnt_d ? wdata1 : wdata0;
      end
      // RAM read data is valid in WAIT; capture it into the granted port at WAIT->RESP.
      if (state_q == WAIT) begin
        if (!gnt_q) begin
          ack0_q <= 1'b1;
          err0_q <= oor;
          if (oor)        rdata0_q <= '0;
          else if (!we_q) rdata0_q <= mem_rdata;
        end else begin
          ack1_q <= 1'b1;
          err1_q <= oor;
          if (oor)        rdata1_q <= '0;
          else if (!we_q) rdata1_q <= mem_rdata;
        end
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, scoreboard-based bench for ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_arbiter;

  logic        clock, rst_n;
  logic        req0, req1, we0, we1;
  logic [8:0]  addr0, addr1, mem_addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic        ack0, ack1, err0, err1, mem_wr, mem_rd;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram [512];
  logic [31:0] model_mem [256];
  logic [31:0] model_rd [2];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;

  ram_arbiter dut (
    .clock(clock), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clock) begin
    if (mem_wr && mem_rd) check("strobe_exclusive", {mem_wr, mem_rd}, 2'b00);
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {ack1, ack0}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {ack1, ack0}, e.port ? 2'b10 : 2'b01);
        check("err", e.port ? err1 : err0, e.err);
        check("rdata", e.port ? rdata1 : rdata0, e.rdata);
      end
    end
  end

  task automatic run_txn(input bit sync, input bit p, input bit we, input logic [8:0] a,
                         input logic [31:0] d, input bit scramble);
    bit          oor;
    bit          got;
    int          t0;
    exp_t        e;
    oor = (a >= 9'd256);
    e.port  = p;
    e.err   = oor;
    e.rdata = oor ? 32'h0 : (we ? model_rd[p] : model_mem[a[7:0]]);
    if (we && !oor) model_mem[a[7:0]] = d;
    model_rd[p] = e.rdata;
    if (sync) @(negedge clock);
    t0 = cyc;
    if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    sb.push_back(e);
    @(negedge clock);
    req0 = 1'b0;
    req1 = 1'b0;
    if (scramble) begin
      if (!p) begin addr0 = a ^ 9'h0AA; wdata0 = ~d; end
      else    begin addr1 = a ^ 9'h0AA; wdata1 = ~d; end
    end
    check("issue_wr", mem_wr, we && !oor);
    check("issue_rd", mem_rd, !we && !oor);
    if (!oor) begin
      check("issue_addr", mem_addr, a);
      check("issue_wdata", mem_wdata, d);
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      if (ack0 || ack1) got = 1'b1;
      else check("strobe_quiet", {mem_wr, mem_rd}, 2'b00);
    end
    check("ack_seen", got, 1'b1);
    check("latency", cyc - t0, 3);
    check("other_rdata", p ? rdata0 : rdata1, model_rd[!p]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {ack0, ack1, err0, err1, mem_wr, mem_rd}, 6'b0);
    check({tag, "_rdata0"}, rdata0, 32'h0);
    check({tag, "_rdata1"}, rdata1, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 9'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int t0, prev, k;
    bit got;
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_txn(1'b1, 1'b0, 1'b1, 9'h000, 32'h2245_0000, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 9'h000, 32'h0, 1'b0);

    // Contention: both requests held for four back-to-back transactions.
    @(negedge clock);
    t0 = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h005;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
`ifdef RAM_ARB_FIXED_PRIO_EN
      e.port = 1'b0;
`else
      e.port = i[0];
`endif
      e.err   = 1'b0;
      e.rdata = e.port ? model_mem[5] : model_mem[0];
      model_rd[e.port] = e.rdata;
      sb.push_back(e);
    end
    prev = t0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      k = 0;
      while (!got && k < 10) begin
        @(negedge clock);
        k++;
        if (ack0 || ack1) got = 1'b1;
      end
      check("cont_ack_seen", got, 1'b1);
      check(i == 0 ? "cont_first_lat" : "cont_ack_gap", cyc - prev, i == 0 ? 3 : 4);
      prev = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    run_txn(1'b1, 1'b0, 1'b0, 9'h100, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b1, 9'h010, 32'hA5A5_0001, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 9'h010, 32'h0, 1'b1);
    run_txn(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

    // Reset asserted while the transaction sits in WAIT.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h000;
    @(negedge clock);
    req0 = 1'b0;
    @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    check_all_zero("midreset");
    rst_n = 1'b1;
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    run_txn(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
